// File: rtl/wb_byte_ram.sv
// Wishbone-slave 32-bit word RAM: byte-lane writes, WAIT_STATES extra cycles before ack.
// Optional WB_BYTE_RAM_RANGE_CHECK_EN: out-of-range addresses answer with err and no access.
//
// state  | meaning
// S_IDLE | waiting for cyc & stb; request fields latched on acceptance
// S_WAIT | counting down wait states; cyc drop aborts the transfer
// S_RESP | ack or err high for this single cycle
// S_GAP  | one dead cycle so a held stb is never acknowledged twice
module wb_byte_ram #(
  parameter int ADDR_BITS   = 7,
  parameter int WAIT_STATES = 1
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        wbs_cyc_i,
  input  logic        wbs_stb_i,
  input  logic        wbs_we_i,
  input  logic [3:0]  wbs_sel_i,
  input  logic [31:0] wbs_adr_i,
  input  logic [31:0] wbs_dat_i,
  output logic        wbs_ack_o,
  output logic        wbs_err_o,
  output logic [31:0] wbs_dat_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP, S_GAP} state_t;

  localparam int DEPTH = 1 << ADDR_BITS;
  localparam logic [3:0] CNT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  state_t               state, state_nxt;
  logic [3:0]           cnt, cnt_nxt;
  logic [ADDR_BITS-1:0] idx_q;
  logic                 we_q;
  logic [3:0]           sel_q;
  logic [31:0]          dat_q;
  logic                 oor_q;
  logic                 ack_q, err_q;
  logic [31:0]          rd_q;

  logic                 req, in_idle, go_resp, adr_oor;
  logic [ADDR_BITS-1:0] cur_idx;
  logic                 cur_we, cur_oor;
  logic [3:0]           cur_sel;
  logic [31:0]          cur_dat;
  logic                 unused_ok;

  logic [31:0] mem [DEPTH];

  assign req     = wbs_cyc_i & wbs_stb_i;
  assign in_idle = (state == S_IDLE);

`ifdef WB_BYTE_RAM_RANGE_CHECK_EN
  assign adr_oor   = |wbs_adr_i[31:ADDR_BITS+2];
  assign wbs_err_o = err_q;
  assign unused_ok = &{1'b0, wbs_adr_i[1:0]};
`else
  assign adr_oor   = 1'b0;
  assign wbs_err_o = 1'b0;
  assign unused_ok = &{1'b0, wbs_adr_i[1:0], wbs_adr_i[31:ADDR_BITS+2], err_q};
`endif

  // With zero wait states the response edge is the acceptance edge, so use the live bus.
  assign cur_idx = in_idle ? wbs_adr_i[ADDR_BITS+1:2] : idx_q;
  assign cur_we  = in_idle ? wbs_we_i  : we_q;
  assign cur_sel = in_idle ? wbs_sel_i : sel_q;
  assign cur_dat = in_idle ? wbs_dat_i : dat_q;
  assign cur_oor = in_idle ? adr_oor   : oor_q;

  assign go_resp = (state_nxt == S_RESP);
  assign busy_o  = ~in_idle;

  assign wbs_ack_o = ack_q;
  assign wbs_dat_o = rd_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      S_IDLE: begin
        if (req) begin
          if (WAIT_STATES == 0) begin
            state_nxt = S_RESP;
          end else begin
            state_nxt = S_WAIT;
            cnt_nxt   = CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (!wbs_cyc_i)      state_nxt = S_GAP;
        else if (cnt == 4'd0) state_nxt = S_RESP;
        else                  cnt_nxt   = cnt - 4'd1;
      end
      S_RESP:  state_nxt = S_GAP;
      S_GAP: begin
        state_nxt = S_IDLE;
        cnt_nxt   = 4'd0;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state <= S_IDLE;
      cnt   <= 4'd0;
      idx_q <= '0;
      we_q  <= 1'b0;
      sel_q <= 4'd0;
      dat_q <= 32'd0;
      oor_q <= 1'b0;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      rd_q  <= 32'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (in_idle && req) begin
        idx_q <= wbs_adr_i[ADDR_BITS+1:2];
        we_q  <= wbs_we_i;
        sel_q <= wbs_sel_i;
        dat_q <= wbs_dat_i;
        oor_q <= adr_oor;
      end
      ack_q <= go_resp & ~cur_oor;
      err_q <= go_resp & cur_oor;
      if (go_resp && !cur_we) rd_q <= cur_oor ? 32'd0 : mem[cur_idx];
    end
  end

  // Array is deliberately not reset; the reset guard only blocks a commit while reset is held.
  always_ff @(posedge wb_clk_i) begin
    if (!wb_rst_i && go_resp && cur_we && !cur_oor) begin
      for (int i = 0; i < 4; i++) begin
        if (cur_sel[i]) mem[cur_idx][8*i +: 8] <= cur_dat[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wb_byte_ram.sv
// Directed bench for wb_byte_ram: three instances (0, 1 and 3 wait states) on a shared bus,
// with cyc routed to the instance selected by tgt.
module tb_wb_byte_ram;

  logic        clk = 1'b0;
  logic        rst;
  logic        cyc, stb, we;
  logic [3:0]  sel;
  logic [31:0] adr, wdat;
  int          tgt;

  logic        cyc0, cyc1, cyc3;
  logic        ack0, ack1, ack3, err0, err1, err3, busy0, busy1, busy3;
  logic [31:0] dat0, dat1, dat3;
  logic        mon_ack, mon_err, mon_busy;
  logic [31:0] mon_dat;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign cyc0 = cyc && (tgt == 0);
  assign cyc1 = cyc && (tgt == 1);
  assign cyc3 = cyc && (tgt == 3);

  always_comb begin
    mon_ack = ack1; mon_err = err1; mon_busy = busy1; mon_dat = dat1;
    case (tgt)
      0: begin mon_ack = ack0; mon_err = err0; mon_busy = busy0; mon_dat = dat0; end
      3: begin mon_ack = ack3; mon_err = err3; mon_busy = busy3; mon_dat = dat3; end
      default: ;
    endcase
  end

  wb_byte_ram #(.ADDR_BITS(7), .WAIT_STATES(1)) u_dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc1), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack1), .wbs_err_o(err1),
    .wbs_dat_o(dat1), .busy_o(busy1));

  wb_byte_ram #(.ADDR_BITS(7), .WAIT_STATES(0)) u_ws0 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc0), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack0), .wbs_err_o(err0),
    .wbs_dat_o(dat0), .busy_o(busy0));

  wb_byte_ram #(.ADDR_BITS(7), .WAIT_STATES(3)) u_ws3 (
    .wb_clk_i(clk), .wb_rst_i(rst), .wbs_cyc_i(cyc3), .wbs_stb_i(stb), .wbs_we_i(we),
    .wbs_sel_i(sel), .wbs_adr_i(adr), .wbs_dat_i(wdat), .wbs_ack_o(ack3), .wbs_err_o(err3),
    .wbs_dat_o(dat3), .busy_o(busy3));

  typedef struct {
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t vt [16];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One transfer starting #1 after an edge; exp_dat is the read data, or the held value for writes.
  task automatic do_xfer(input int t, input logic w, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] d, input logic exp_err, input logic [31:0] exp_dat,
                         input string nm);
    int n;
    logic got;
    tgt = t; cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
    n = 0; got = 1'b0;
    while (!got && n < 24) begin
      @(posedge clk); #1;
      n++;
      if (mon_ack || mon_err) got = 1'b1;
    end
    cyc = 1'b0; stb = 1'b0;
    chk({nm, ".latency"}, 32'(n), 32'(t + 1));
    chk({nm, ".ack"}, 32'(mon_ack), 32'(!exp_err));
    chk({nm, ".err"}, 32'(mon_err), 32'(exp_err));
    chk({nm, ".dat"}, mon_dat, exp_dat);
    @(posedge clk); #1;
    chk({nm, ".one_cycle"}, 32'(mon_ack | mon_err), 32'd0);
    @(posedge clk); #1;
    chk({nm, ".busy_idle"}, 32'(mon_busy), 32'd0);
  endtask

  // Reads 0x10 then 0x20 with stb held throughout; expects one ack each, WS+3 apart.
  task automatic held_pair(input int t, input string nm);
    int nacks, first, second;
    tgt = t; cyc = 1'b1; stb = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h10;
    nacks = 0; first = 0; second = 0;
    for (int e = 1; e <= 3 * t + 6; e++) begin
      @(posedge clk); #1;
      if (mon_ack) begin
        nacks++;
        if (nacks == 1) begin
          first = e;
          chk({nm, ".dat0"}, mon_dat, 32'hDEADBEEF);
          adr = 32'h20;
        end else if (nacks == 2) begin
          second = e;
          chk({nm, ".dat1"}, mon_dat, 32'h11BB33A5);
        end
      end
    end
    cyc = 1'b0; stb = 1'b0;
    chk({nm, ".acks"}, 32'(nacks), 32'd2);
    chk({nm, ".first"}, 32'(first), 32'(t + 1));
    chk({nm, ".spacing"}, 32'(second - first), 32'(t + 3));
    repeat (4) @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] last_rd;
    logic [31:0] exp_d;
    int nacks;

    vt[0]  = '{1'b1, 4'hF, 32'h010, 32'hDEADBEEF, 1'b0, 32'h0};
    vt[1]  = '{1'b0, 4'hF, 32'h010, 32'h0,        1'b0, 32'hDEADBEEF};
    vt[2]  = '{1'b1, 4'hF, 32'h020, 32'h11223344, 1'b0, 32'h0};
    vt[3]  = '{1'b1, 4'h5, 32'h020, 32'hAABBCCDD, 1'b0, 32'h0};
    vt[4]  = '{1'b0, 4'hF, 32'h020, 32'h0,        1'b0, 32'h11BB33DD};
    vt[5]  = '{1'b1, 4'h0, 32'h020, 32'h12345678, 1'b0, 32'h0};
    vt[6]  = '{1'b0, 4'hF, 32'h020, 32'h0,        1'b0, 32'h11BB33DD};
    vt[7]  = '{1'b1, 4'h1, 32'h023, 32'h000000A5, 1'b0, 32'h0};
    vt[8]  = '{1'b0, 4'hF, 32'h022, 32'h0,        1'b0, 32'h11BB33A5};
    vt[9]  = '{1'b1, 4'hF, 32'h1FC, 32'h13579BDF, 1'b0, 32'h0};
    vt[10] = '{1'b0, 4'hF, 32'h1FC, 32'h0,        1'b0, 32'h13579BDF};
    vt[11] = '{1'b1, 4'hF, 32'h000, 32'hCAFEF00D, 1'b0, 32'h0};
`ifdef WB_BYTE_RAM_RANGE_CHECK_EN
    vt[12] = '{1'b1, 4'hF, 32'h200, 32'hFEEDFACE, 1'b1, 32'h0};
    vt[13] = '{1'b0, 4'hF, 32'h000, 32'h0,        1'b0, 32'hCAFEF00D};
    vt[14] = '{1'b0, 4'hF, 32'h200, 32'h0,        1'b1, 32'h0};
`else
    vt[12] = '{1'b1, 4'hF, 32'h200, 32'hFEEDFACE, 1'b0, 32'h0};
    vt[13] = '{1'b0, 4'hF, 32'h000, 32'h0,        1'b0, 32'hFEEDFACE};
    vt[14] = '{1'b0, 4'hF, 32'h200, 32'h0,        1'b0, 32'hFEEDFACE};
`endif
    vt[15] = '{1'b0, 4'h0, 32'h1FC, 32'h0,        1'b0, 32'h13579BDF};

    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0; sel = 4'h0; adr = 32'h0; wdat = 32'h0; tgt = 1;
    @(posedge clk); @(posedge clk); #1;
    chk("reset.ack",  32'(ack1),  32'd0);
    chk("reset.err",  32'(err1),  32'd0);
    chk("reset.dat",  dat1,       32'd0);
    chk("reset.busy", 32'(busy1), 32'd0);
    #3 rst = 1'b0;
    @(posedge clk); #1;

    last_rd = 32'h0;
    for (int i = 0; i < 16; i++) begin
      exp_d = vt[i].we ? last_rd : vt[i].rd;
      do_xfer(1, vt[i].we, vt[i].sel, vt[i].adr, vt[i].dat, vt[i].err, exp_d,
              $sformatf("vec%0d", i));
      if (!vt[i].we) last_rd = vt[i].rd;
    end

    // Async reset while a write is waiting: outputs clear at once and the write is lost.
    tgt = 1; cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h10; wdat = 32'h0BAD0BAD;
    @(posedge clk); #1;
    chk("midrst.busy_before", 32'(busy1), 32'd1);
    cyc = 1'b0; stb = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst.ack",  32'(ack1),  32'd0);
    chk("midrst.err",  32'(err1),  32'd0);
    chk("midrst.dat",  dat1,       32'd0);
    chk("midrst.busy", 32'(busy1), 32'd0);
    @(posedge clk); #3 rst = 1'b0;
    @(posedge clk); #1;
    do_xfer(1, 1'b0, 4'hF, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF, "midrst.read");

    held_pair(1, "held_ws1");

    do_xfer(0, 1'b1, 4'hF, 32'h10, 32'hDEADBEEF, 1'b0, 32'h0, "ws0.wr10");
    do_xfer(0, 1'b1, 4'hF, 32'h20, 32'h11BB33A5, 1'b0, 32'h0, "ws0.wr20");
    held_pair(0, "held_ws0");

    // Abort on the 3-wait-state instance: cyc drops one cycle into WAIT.
    do_xfer(3, 1'b1, 4'hF, 32'h40, 32'h00000077, 1'b0, 32'h0, "ws3.wr40");
    tgt = 3; cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = 32'h40; wdat = 32'h5;
    @(posedge clk); #1;
    chk("abort.busy", 32'(busy3), 32'd1);
    cyc = 1'b0;
    nacks = 0;
    for (int e = 0; e < 6; e++) begin
      @(posedge clk); #1;
      if (ack3 || err3) nacks++;
    end
    stb = 1'b0;
    chk("abort.acks", 32'(nacks), 32'd0);
    chk("abort.busy_after", 32'(busy3), 32'd0);
    do_xfer(3, 1'b0, 4'hF, 32'h40, 32'h0, 1'b0, 32'h00000077, "abort.read");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
